captura_jogada: RTL and testbench

- Player-side receiver for the note/time memory game.
- The presentation path sends notes to the player on `leds` and `pulso_buzzer`. This block is the return path: it watches the 12 note buttons, identifies the note pressed and measures how long it was held.
- It then compares both against the expected note/time word from memory and reports `nota_correta` and `tempo_correto`.
- It sits in the datapath between the `botoes` pins and the main control FSM. It replaces ad-hoc edge detection and timers.

---
 rtl/jogo_pkg.sv | 35 +++
 rtl/captura_jogada_if.sv | 28 ++
 rtl/captura_jogada_debounce_contador.sv | 30 +++
 rtl/captura_jogada.sv | 213 +++++++++++++++++++++
 tb/tb_captura_jogada.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the note/time game player-side capture path.
package jogo_pkg;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ESPERA      = 3'd1,
    DEB_PRESSAO = 3'd2,
    MEDINDO     = 3'd3,
    SOLTURA     = 3'd4,
    COMPARA     = 3'd5,
    FIM         = 3'd6
  } estado_t;

  localparam logic [3:0] NOTA_INVALIDA = 4'hF;
  localparam int         NUM_BOTOES    = 12;

  // Index of the single set bit; NOTA_INVALIDA for zero or several bits set.
  function automatic logic [3:0] onehot_para_indice(input logic [NUM_BOTOES-1:0] valor);
    logic [3:0] indice;
    int         ativos;
    indice = NOTA_INVALIDA;
    ativos = 0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      if (valor[i]) begin
        ativos = ativos + 1;
        indice = 4'(i);
      end
    end
    if (ativos != 1) begin
      indice = NOTA_INVALIDA;
    end
    return indice;
  endfunction

endpackage

// File: rtl/captura_jogada_if.sv
// Bus between the main control FSM (master) and the capture block (slave).
interface captura_jogada_if #(parameter int LARGURA = 16) ();
  import jogo_pkg::*;

  logic                  habilitar;
  logic                  limpar;
  logic [NUM_BOTOES-1:0] botoes;
  logic [3:0]            nota_esperada;
  logic [3:0]            tempo_esperado;
  logic                  pronto;
  logic                  nota_correta;
  logic                  tempo_correto;
  logic                  timeout;
  logic [3:0]            nota_capturada;
  logic [LARGURA-1:0]    duracao;
  logic [2:0]            db_estado;

  modport master (
    output habilitar, limpar, botoes, nota_esperada, tempo_esperado,
    input  pronto, nota_correta, tempo_correto, timeout, nota_capturada, duracao, db_estado
  );

  modport slave (
    input  habilitar, limpar, botoes, nota_esperada, tempo_esperado,
    output pronto, nota_correta, tempo_correto, timeout, nota_capturada, duracao, db_estado
  );

endinterface

// File: rtl/captura_jogada_debounce_contador.sv
// Saturating stable-sample counter: clear, load-one and increment controls.
module debounce_contador #(
  parameter int LARGURA = 16,
  parameter int LIMITE  = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zerar,
  input  logic               carregar,
  input  logic               incrementar,
  output logic [LARGURA-1:0] contagem
);

  localparam logic [LARGURA-1:0] TETO = LARGURA'(LIMITE);
  localparam logic [LARGURA-1:0] UM   = LARGURA'(1);

  // Count consecutive samples, holding at LIMITE once reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (zerar) begin
      contagem <= '0;
    end else if (carregar) begin
      contagem <= UM;
    end else if (incrementar && (contagem != TETO)) begin
      contagem <= contagem + UM;
    end
  end

endmodule

// File: rtl/captura_jogada.sv
// Player-side receiver: debounces the note buttons, measures the hold time
// and grades note and duration against the expected word.
module captura_jogada
  import jogo_pkg::*;
#(
  parameter int CLOCK_FREQ = 5000,
  parameter int LARGURA    = 16,
  parameter int DEBOUNCE   = 5,
  parameter int TOLERANCIA = 1000,
  parameter int TIMEOUT    = 25000
) (
  input  logic             clock,
  input  logic             reset,
  captura_jogada_if.slave  bus
);

  localparam int                 LS        = $clog2(DEBOUNCE + 1);
  localparam int                 TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TIMER_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0]      TIMER_FIM = TW'(TIMEOUT - 1);
  localparam logic [LARGURA-1:0] DEB_CNT   = LARGURA'(DEBOUNCE);
  localparam logic [LS-1:0]      DEB_SOL   = LS'(DEBOUNCE);
  localparam logic [LARGURA:0]   QUARTO    = (LARGURA+1)'(CLOCK_FREQ / 4);
  localparam logic [LARGURA:0]   TOL       = (LARGURA+1)'(TOLERANCIA);

  estado_t               estado;
  logic [NUM_BOTOES-1:0] sinc1, sinc2, padrao;
  logic                  troca;
  logic [TW-1:0]         timer;
  logic                  pronto, nota_correta, tempo_correto, timeout;
  logic [3:0]            nota_capturada;
  logic [LARGURA-1:0]    duracao;
  logic [LARGURA-1:0]    contagem;
  logic [LS-1:0]         cont_sol;
  logic                  cnt_zerar, cnt_carregar, cnt_incr;
  logic                  sol_zerar, sol_carregar, sol_incr;
  logic                  tem_botao;
  logic [LARGURA:0]      esperado, dur_ext, diferenca;
  logic                  tempo_ok;

  assign tem_botao = |sinc2;

  // Press counter doubles as the hold-time counter, saturating at full scale.
  debounce_contador #(.LARGURA(LARGURA), .LIMITE((2**LARGURA) - 1)) u_pressao (
    .clock(clock), .reset(reset), .zerar(cnt_zerar), .carregar(cnt_carregar),
    .incrementar(cnt_incr), .contagem(contagem)
  );

  // Release counter confirms DEBOUNCE consecutive zero samples.
  debounce_contador #(.LARGURA(LS), .LIMITE(DEBOUNCE)) u_soltura (
    .clock(clock), .reset(reset), .zerar(sol_zerar), .carregar(sol_carregar),
    .incrementar(sol_incr), .contagem(cont_sol)
  );

  // Two-flop synchronizer; both edges see the same delay so duration is exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1 <= '0;
      sinc2 <= '0;
    end else begin
      sinc1 <= bus.botoes;
      sinc2 <= sinc1;
    end
  end

  // Counter controls derived from the current state and synchronized buttons.
  always_comb begin
    cnt_zerar    = 1'b0;
    cnt_carregar = 1'b0;
    cnt_incr     = 1'b0;
    sol_zerar    = 1'b0;
    sol_carregar = 1'b0;
    sol_incr     = 1'b0;
    if (bus.limpar) begin
      cnt_zerar = 1'b1;
      sol_zerar = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          cnt_zerar = bus.habilitar;
          sol_zerar = bus.habilitar;
        end
        ESPERA:      cnt_carregar = tem_botao;
        DEB_PRESSAO: begin
          cnt_incr     = 1'b1;
          sol_carregar = !tem_botao;
        end
        MEDINDO: begin
          cnt_incr     = 1'b1;
          sol_carregar = !tem_botao;
        end
        SOLTURA: begin
          cnt_incr = 1'b1;
          sol_incr = !tem_botao;
        end
        default: cnt_incr = 1'b0;
      endcase
    end
  end

  // Duration grading: expected time in cycles and absolute difference.
  always_comb begin
    esperado  = QUARTO * (LARGURA+1)'(bus.tempo_esperado);
    dur_ext   = {1'b0, duracao};
    diferenca = (dur_ext >= esperado) ? (dur_ext - esperado) : (esperado - dur_ext);
    tempo_ok  = (diferenca <= TOL);
  end

  // Capture FSM with registered result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= OCIOSO;
      pronto         <= 1'b0;
      nota_correta   <= 1'b0;
      tempo_correto  <= 1'b0;
      timeout        <= 1'b0;
      nota_capturada <= NOTA_INVALIDA;
      duracao        <= '0;
      padrao         <= '0;
      troca          <= 1'b0;
      timer          <= '0;
    end else begin
      pronto <= 1'b0;
      if (bus.limpar) begin
        estado         <= OCIOSO;
        nota_correta   <= 1'b0;
        tempo_correto  <= 1'b0;
        timeout        <= 1'b0;
        nota_capturada <= NOTA_INVALIDA;
        duracao        <= '0;
        padrao         <= '0;
        troca          <= 1'b0;
        timer          <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (bus.habilitar) begin
              nota_correta   <= 1'b0;
              tempo_correto  <= 1'b0;
              timeout        <= 1'b0;
              nota_capturada <= NOTA_INVALIDA;
              duracao        <= '0;
              troca          <= 1'b0;
              timer          <= '0;
              estado         <= ESPERA;
            end
          end
          ESPERA: begin
            if (timer != TIMER_MAX) timer <= timer + TW'(1);
            if (tem_botao) begin
              padrao <= sinc2;
              estado <= DEB_PRESSAO;
            end else if (timer >= TIMER_FIM) begin
              timeout       <= 1'b1;
              nota_correta  <= 1'b0;
              tempo_correto <= 1'b0;
              pronto        <= 1'b1;
              estado        <= FIM;
            end
          end
          DEB_PRESSAO: begin
            // The wait timer keeps running so glitches cannot extend the window.
            if (timer != TIMER_MAX) timer <= timer + TW'(1);
            if (!tem_botao) begin
              if (contagem >= DEB_CNT) begin
                nota_capturada <= onehot_para_indice(padrao);
                duracao        <= contagem;
                estado         <= SOLTURA;
              end else begin
                estado <= ESPERA;
              end
            end else if (contagem >= DEB_CNT) begin
              nota_capturada <= onehot_para_indice(padrao);
              estado         <= MEDINDO;
            end
          end
          MEDINDO: begin
            if (!tem_botao) begin
              duracao <= contagem;
              estado  <= SOLTURA;
            end else if (sinc2 != padrao) begin
              troca <= 1'b1;
            end
          end
          SOLTURA: begin
            if (tem_botao) begin
              estado <= MEDINDO;
            end else if (cont_sol == DEB_SOL) begin
              estado <= COMPARA;
            end
          end
          COMPARA: begin
            nota_correta  <= (nota_capturada == bus.nota_esperada) && !troca;
            tempo_correto <= tempo_ok;
            pronto        <= 1'b1;
            estado        <= FIM;
          end
          FIM:     estado <= OCIOSO;
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.pronto         = pronto;
  assign bus.nota_correta   = nota_correta;
  assign bus.tempo_correto  = tempo_correto;
  assign bus.timeout        = timeout;
  assign bus.nota_capturada = nota_capturada;
  assign bus.duracao        = duracao;
  assign bus.db_estado      = estado;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada with hand-computed expectations.
module tb_captura_jogada;

  localparam int DEB = 5;

  logic clock = 1'b0;
  logic reset;
  int   vetores = 0;
  int   erros   = 0;
  int   pulsos  = 0;
  int   lat;
  int   p0;

  captura_jogada_if #(.LARGURA(16)) bus ();

  captura_jogada #(
    .CLOCK_FREQ(5000), .LARGURA(16), .DEBOUNCE(DEB), .TOLERANCIA(1000), .TIMEOUT(25000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Count every pronto pulse, sampled on the falling edge.
  always @(negedge clock) begin
    if (bus.pronto === 1'b1) pulsos++;
  end

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic arma(input logic [3:0] nota, input logic [3:0] tempo);
    bus.nota_esperada  = nota;
    bus.tempo_esperado = tempo;
    bus.habilitar      = 1'b1;
    ciclos(1);
    bus.habilitar      = 1'b0;
  endtask

  task automatic aplica(input logic [11:0] padrao, input int n);
    bus.botoes = padrao;
    ciclos(n);
  endtask

  task automatic espera_pronto(input int limite, output int l);
    l = 0;
    while (l < limite && bus.pronto !== 1'b1) begin
      ciclos(1);
      l++;
    end
    if (bus.pronto !== 1'b1) l = -1;
  endtask

  task automatic confere_saidas(input string tag, input logic [3:0] cap, input int dur,
                                input logic nc, input logic tc, input logic to);
    confere({tag, " nota_capturada"}, 32'(bus.nota_capturada), 32'(cap));
    confere({tag, " duracao"},        32'(bus.duracao),        dur);
    confere({tag, " nota_correta"},   32'(bus.nota_correta),   32'(nc));
    confere({tag, " tempo_correto"},  32'(bus.tempo_correto),  32'(tc));
    confere({tag, " timeout"},        32'(bus.timeout),        32'(to));
  endtask

  // Release the buttons, wait for the result and grade it.
  task automatic solta_e_confere(input string tag, input logic [3:0] cap, input int dur,
                                 input logic nc, input logic tc);
    int l;
    bus.botoes = 12'b0;
    espera_pronto(40, l);
    confere({tag, " latencia"}, l, DEB + 4);
    confere_saidas(tag, cap, dur, nc, tc, 1'b0);
    ciclos(1);
    confere({tag, " pronto 1 ciclo"}, 32'(bus.pronto), 32'd0);
    confere({tag, " volta ocioso"},   32'(bus.db_estado), 32'd0);
  endtask

  task automatic jogada(input string tag, input logic [11:0] padrao, input int hold,
                        input logic [3:0] nota, input logic [3:0] tempo,
                        input logic [3:0] cap, input logic nc, input logic tc);
    arma(nota, tempo);
    aplica(padrao, hold);
    solta_e_confere(tag, cap, hold, nc, tc);
  endtask

  initial begin
    reset              = 1'b1;
    bus.habilitar      = 1'b0;
    bus.limpar         = 1'b0;
    bus.botoes         = 12'b0;
    bus.nota_esperada  = 4'd0;
    bus.tempo_esperado = 4'd0;
    ciclos(3);
    reset = 1'b0;
    ciclos(2);

    confere("reset pronto", 32'(bus.pronto), 32'd0);
    confere("reset estado", 32'(bus.db_estado), 32'd0);
    confere_saidas("reset", 4'hF, 0, 1'b0, 1'b0, 1'b0);

    // Nominal hold and the tolerance boundaries around 7500 cycles.
    jogada("base 7500", 12'b100, 7500, 4'd2, 4'd6, 4'd2, 1'b1, 1'b1);
    jogada("hold 3000", 12'b100, 3000, 4'd2, 4'd6, 4'd2, 1'b1, 1'b0);
    jogada("hold 7120", 12'b100, 7120, 4'd2, 4'd6, 4'd2, 1'b1, 1'b1);
    jogada("hold 8500", 12'b100, 8500, 4'd2, 4'd6, 4'd2, 1'b1, 1'b1);
    jogada("hold 8501", 12'b100, 8501, 4'd2, 4'd6, 4'd2, 1'b1, 1'b0);

    // Second expected word: right note/long hold, then wrong note/exact hold.
    jogada("nota4 13100", 12'b10000, 13100, 4'd4, 4'd8, 4'd4, 1'b1, 1'b0);
    jogada("nota2 vs 4",  12'b100,   10000, 4'd4, 4'd8, 4'd2, 1'b0, 1'b1);

    // Two buttons at once.
    jogada("multi", 12'b10100, 200, 4'd2, 4'd6, 4'hF, 1'b0, 1'b0);

    // Note changes mid-hold.
    arma(4'd2, 4'd6);
    aplica(12'b100, 300);
    aplica(12'b1000, 300);
    solta_e_confere("troca", 4'd2, 600, 1'b0, 1'b0);

    // Short press glitch is ignored; a real press afterwards still works.
    arma(4'd2, 4'd6);
    p0 = pulsos;
    aplica(12'b100, 3);
    aplica(12'b0, 20);
    confere("glitch sem pronto", pulsos - p0, 0);
    confere("glitch espera", 32'(bus.db_estado), 32'd1);
    aplica(12'b100, 500);
    solta_e_confere("pos glitch", 4'd2, 500, 1'b1, 1'b0);

    // Release bounce inside a 7500-cycle hold yields one result.
    arma(4'd2, 4'd6);
    p0 = pulsos;
    aplica(12'b100, 4000);
    aplica(12'b0, 3);
    aplica(12'b100, 3497);
    solta_e_confere("bounce", 4'd2, 7500, 1'b1, 1'b1);
    ciclos(20);
    confere("bounce um pronto", pulsos - p0, 1);

    // No press at all: timeout after TIMEOUT+1 cycles from habilitar.
    arma(4'd2, 4'd6);
    espera_pronto(25100, lat);
    confere("timeout latencia", (lat < 0) ? lat : lat + 1, 25001);
    confere_saidas("timeout", 4'hF, 0, 1'b0, 1'b0, 1'b1);
    ciclos(1);
    confere("timeout pronto 1 ciclo", 32'(bus.pronto), 32'd0);

    // Reset while measuring.
    arma(4'd2, 4'd6);
    aplica(12'b100, 100);
    confere("pre reset medindo", 32'(bus.db_estado), 32'd3);
    confere("pre reset nota", 32'(bus.nota_capturada), 32'd2);
    reset = 1'b1;
    ciclos(2);
    bus.botoes = 12'b0;
    reset = 1'b0;
    p0 = pulsos;
    ciclos(1);
    confere("reset meio estado", 32'(bus.db_estado), 32'd0);
    confere_saidas("reset meio", 4'hF, 0, 1'b0, 1'b0, 1'b0);
    ciclos(20);
    confere("reset meio sem pronto", pulsos - p0, 0);

    // Synchronous abort while measuring.
    arma(4'd2, 4'd6);
    aplica(12'b100, 100);
    confere("pre limpar medindo", 32'(bus.db_estado), 32'd3);
    p0 = pulsos;
    bus.limpar = 1'b1;
    ciclos(1);
    bus.limpar = 1'b0;
    confere("limpar estado", 32'(bus.db_estado), 32'd0);
    confere_saidas("limpar", 4'hF, 0, 1'b0, 1'b0, 1'b0);
    bus.botoes = 12'b0;
    ciclos(20);
    confere("limpar sem pronto", pulsos - p0, 0);
    confere("limpar ocioso", 32'(bus.db_estado), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
